// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory port.
interface mem_bus_arbiter_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    // Instruction-fetch requester
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    // Data requester
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [SW-1:0] d_sel;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    // Shared status
    logic          bus_err;
    logic          stallreq;

    // Memory port
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_sel;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_sel, d_wdata,
               mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, bus_err, stallreq,
               mem_ce, mem_we, mem_addr, mem_sel, mem_wdata
    );

    // Requester / memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_sel, d_wdata,
               mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, bus_err, stallreq,
               mem_ce, mem_we, mem_addr, mem_sel, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority (data over fetch) arbiter onto a single memory port with a
// busy-cycle timeout that completes the transfer with bus_err.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] IF_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY  = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          mem_ce_q,    mem_ce_d;
    logic          mem_we_q,    mem_we_d;
    logic [31:0]   mem_addr_q,  mem_addr_d;
    logic [3:0]    mem_sel_q,   mem_sel_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   if_rdata_q,  if_rdata_d;
    logic [31:0]   d_rdata_q,   d_rdata_d;
    logic          if_ack_q,    if_ack_d;
    logic          d_ack_q,     d_ack_d;
    logic          bus_err_q,   bus_err_d;

    // Next-state and registered-output logic; acks and bus_err are pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_ce_d    = mem_ce_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_sel_d   = mem_sel_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.d_req) begin
                    state_d     = D_BUSY;
                    cnt_d       = '0;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_sel_d   = bus.d_sel;
                    mem_wdata_d = bus.d_wdata;
                end else if (bus.if_req) begin
                    state_d     = IF_BUSY;
                    cnt_d       = '0;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_sel_d   = 4'b1111;
                    mem_wdata_d = 32'h0;
                end
            end

            IF_BUSY, D_BUSY: begin
                if (bus.mem_ready) begin
                    // Normal completion wins over a simultaneous timeout
                    state_d  = RESP;
                    mem_ce_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == IF_BUSY) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_ack_d    = 1'b1;
                        d_rdata_d  = bus.mem_rdata;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d   = RESP;
                    mem_ce_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == IF_BUSY) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = 32'h0;
                    end else begin
                        d_ack_d    = 1'b1;
                        d_rdata_d  = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_sel_q   <= 4'h0;
            mem_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_sel_q   <= mem_sel_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.mem_ce    = mem_ce_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.bus_err   = bus_err_q;

    // Stall while any requester is waiting on an outstanding ack.
    assign bus.stallreq = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed table, hand sequences for
// contention and reset, and randomized transfers against a transaction model.
module tb_mem_bus_arbiter;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model of the per-port read-data registers
    logic [31:0] exp_if_rd;
    logic [31:0] exp_d_rd;
    bit          d_rd_known;

    typedef struct {
        bit          if_req;
        bit          d_req;
        bit          d_we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          n_ready;
        logic [31:0] mem_data;
        bit          x_is_d;
        int          x_lat;
        bit          x_err;
        logic [31:0] x_rd;
        bit          x_chk_rd;
        bit          x_we;
        logic [3:0]  x_sel;
        logic [31:0] x_wdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer from the grant edge through RESP back to IDLE.
    task automatic run_xfer(input bit is_d, input int n_ready, input int lat,
                            input bit err, input logic [31:0] mem_data,
                            input logic [31:0] exp_rd, input bit chk_rd,
                            input bit exp_we, input logic [31:0] exp_addr,
                            input logic [3:0] exp_sel, input logic [31:0] exp_wdata);
        bit loser;
        step();
        for (int k = 1; k <= lat; k++) begin
            chk("busy_ce",    32'(bus.mem_ce), 32'(1'b1));
            chk("busy_we",    32'(bus.mem_we), 32'(exp_we));
            chk("busy_addr",  bus.mem_addr, exp_addr);
            chk("busy_sel",   32'(bus.mem_sel), 32'(exp_sel));
            chk("busy_wdata", bus.mem_wdata, exp_wdata);
            chk("busy_acks",  32'({bus.if_ack, bus.d_ack, bus.bus_err}), 32'(3'b000));
            chk("busy_stall", 32'(bus.stallreq), 32'(1'b1));
            if (k == n_ready) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_data;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
            end
            step();
        end
        loser = is_d ? bus.if_req : bus.d_req;
        chk("resp_if_ack", 32'(bus.if_ack),  32'(!is_d));
        chk("resp_d_ack",  32'(bus.d_ack),   32'(is_d));
        chk("resp_err",    32'(bus.bus_err), 32'(err));
        chk("resp_ce",     32'(bus.mem_ce),  32'(1'b0));
        chk("resp_we",     32'(bus.mem_we),  32'(1'b0));
        chk("resp_stall",  32'(bus.stallreq), 32'(loser));
        if (is_d) begin
            if (chk_rd) chk("resp_d_rdata", bus.d_rdata, exp_rd);
            chk("hold_if_rdata", bus.if_rdata, exp_if_rd);
            exp_d_rd   = exp_rd;
            d_rd_known = chk_rd;
            bus.d_req  = 1'b0;
        end else begin
            chk("resp_if_rdata", bus.if_rdata, exp_rd);
            if (d_rd_known) chk("hold_d_rdata", bus.d_rdata, exp_d_rd);
            exp_if_rd  = exp_rd;
            bus.if_req = 1'b0;
        end
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        step();
        chk("idle_acks",  32'({bus.if_ack, bus.d_ack, bus.bus_err}), 32'(3'b000));
        chk("idle_ce",    32'(bus.mem_ce), 32'(1'b0));
        chk("idle_stall", 32'(bus.stallreq), 32'(bus.if_req | bus.d_req));
        bus.mem_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int r;
        bit is_d;
        int n;
        int lat;
        bit err;
        logic [31:0] md;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 2, 32'h3401_1100,
                    1'b0, 2, 1'b0, 32'h3401_1100, 1'b1, 1'b0, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 4'h5, 32'h1234_5678, 1, 32'hCAFE_F00D,
                    1'b1, 1, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 4'h5, 32'h1234_5678};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'h0, 5, 32'h5555_AAAA,
                    1'b1, 4, 1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0044, 4'h0, 32'h0, 4, 32'h0BAD_F00D,
                    1'b0, 4, 1'b0, 32'h0BAD_F00D, 1'b1, 1'b0, 4'hF, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0080, 4'h3, 32'hDEAD_BEEF, 3, 32'h1111_2222,
                    1'b1, 3, 1'b0, 32'h0, 1'b0, 1'b1, 4'h3, 32'hDEAD_BEEF};

        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0;
        bus.d_sel     = 4'h0;
        bus.d_wdata   = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ready = 1'b0;
        exp_if_rd     = 32'h0;
        exp_d_rd      = 32'h0;
        d_rd_known    = 1'b1;

        // Reset state
        #1;
        chk("rst_ce",     32'(bus.mem_ce), 32'(1'b0));
        chk("rst_we",     32'(bus.mem_we), 32'(1'b0));
        chk("rst_addr",   bus.mem_addr, 32'h0);
        chk("rst_sel",    32'(bus.mem_sel), 32'(4'h0));
        chk("rst_wdata",  bus.mem_wdata, 32'h0);
        chk("rst_ifrd",   bus.if_rdata, 32'h0);
        chk("rst_drd",    bus.d_rdata, 32'h0);
        chk("rst_acks",   32'({bus.if_ack, bus.d_ack, bus.bus_err}), 32'(3'b000));
        #11;
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].if_req) begin
                bus.if_addr = vecs[i].addr;
                bus.if_req  = 1'b1;
            end
            if (vecs[i].d_req) begin
                bus.d_we    = vecs[i].d_we;
                bus.d_addr  = vecs[i].addr;
                bus.d_sel   = vecs[i].sel;
                bus.d_wdata = vecs[i].wdata;
                bus.d_req   = 1'b1;
            end
            run_xfer(vecs[i].x_is_d, vecs[i].n_ready, vecs[i].x_lat, vecs[i].x_err,
                     vecs[i].mem_data, vecs[i].x_rd, vecs[i].x_chk_rd, vecs[i].x_we,
                     vecs[i].addr, vecs[i].x_sel, vecs[i].x_wdata);
        end

        // Contention: data write first, fetch granted two edges after d_ack
        bus.if_addr = 32'h0000_0010;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0080;
        bus.d_sel   = 4'b0011;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b1;
        run_xfer(1'b1, 1, 1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 4'b0011, 32'hDEAD_BEEF);
        run_xfer(1'b0, 2, 2, 1'b0, 32'h3401_1100, 32'h3401_1100, 1'b1, 1'b0,
                 32'h10, 4'hF, 32'h0);

        // Reset in the middle of a data transfer
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0000_0090;
        bus.d_sel     = 4'hF;
        bus.d_wdata   = 32'h0;
        bus.d_req     = 1'b1;
        bus.mem_ready = 1'b0;
        step();
        chk("mid_ce", 32'(bus.mem_ce), 32'(1'b1));
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("async_ce",   32'(bus.mem_ce), 32'(1'b0));
        chk("async_dack", 32'(bus.d_ack), 32'(1'b0));
        chk("async_drd",  bus.d_rdata, 32'h0);
        chk("async_ifrd", bus.if_rdata, 32'h0);
        bus.mem_ready = 1'b1;
        step();
        chk("inrst_dack", 32'(bus.d_ack), 32'(1'b0));
        chk("inrst_ce",   32'(bus.mem_ce), 32'(1'b0));
        #3;
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        exp_if_rd  = 32'h0;
        exp_d_rd   = 32'h0;
        d_rd_known = 1'b1;
        run_xfer(1'b1, 2, 2, 1'b0, 32'h0246_8ACE, 32'h0246_8ACE, 1'b1, 1'b0,
                 32'h90, 4'hF, 32'h0);

        // Randomized transfers against the transaction model
        for (int t = 0; t < 150; t++) begin
            if (!bus.if_req && !bus.d_req) begin
                r = int'($urandom_range(0, 3));
                if (r == 0) begin
                    bus.mem_ready = 1'($urandom_range(0, 1));
                    step();
                    chk("rnd_idle_ce",   32'(bus.mem_ce), 32'(1'b0));
                    chk("rnd_idle_acks", 32'({bus.if_ack, bus.d_ack, bus.bus_err}), 32'(3'b000));
                    chk("rnd_idle_stall", 32'(bus.stallreq), 32'(1'b0));
                    continue;
                end
                if (r[0]) begin
                    bus.if_addr = $urandom;
                    bus.if_req  = 1'b1;
                end
                if (r[1]) begin
                    bus.d_we    = 1'($urandom_range(0, 1));
                    bus.d_addr  = $urandom;
                    bus.d_sel   = 4'($urandom_range(0, 15));
                    bus.d_wdata = $urandom;
                    bus.d_req   = 1'b1;
                end
            end else if (!bus.d_req && ($urandom_range(0, 1) == 1)) begin
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom;
                bus.d_sel   = 4'($urandom_range(0, 15));
                bus.d_wdata = $urandom;
                bus.d_req   = 1'b1;
            end
            is_d = bus.d_req;
            n    = int'($urandom_range(1, TO + 2));
            err  = (n > int'(TO));
            lat  = err ? int'(TO) : n;
            md   = $urandom;
            if (is_d)
                run_xfer(1'b1, n, lat, err, md, err ? 32'h0 : md,
                         !(bus.d_we && !err), bus.d_we, bus.d_addr, bus.d_sel, bus.d_wdata);
            else
                run_xfer(1'b0, n, lat, err, md, err ? 32'h0 : md,
                         1'b1, 1'b0, bus.if_addr, 4'hF, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the number of busy cycles without mem_ready before a bus error is declared (legal range 2..255).
REQ-002 The block SHALL have these ports, one per line:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  instruction-fetch read request; level, held until if_ack.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetch read data; registered.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  data write enable (1 = write).
- d_addr  in  32  data address.
- d_sel  in  4  data byte select.
- d_wdata  in  32  data write data.
- d_rdata  out  32  data read data; registered.
- d_ack  out  1  one-cycle data completion pulse.
- bus_err  out  1  high together with an ack when that transfer timed out.
- mem_ce  out  1  memory chip enable; registered.
- mem_we  out  1  memory write enable; registered.
- mem_addr  out  32  memory address; registered.
- mem_sel  out  4  memory byte select; registered.
- mem_wdata  out  32  memory write data; registered.
- mem_rdata  in  32  memory read data; valid when mem_ready = 1.
- mem_ready  in  1  memory completion strobe.
- stallreq  out  1  pipeline stall request.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, IF_BUSY, D_BUSY and RESP.
REQ-004 In IDLE, if d_req = 1 the FSM SHALL go to D_BUSY; otherwise, if if_req = 1 it SHALL go to IF_BUSY; otherwise it SHALL stay in IDLE.
REQ-005 When both requests are high in IDLE, the data requester SHALL win (fixed priority).
REQ-006 On the grant edge, the block SHALL register the winner's command onto the mem_* outputs and set mem_ce = 1.
- Fetch grant: mem_we = 0, mem_sel = 4'b1111, mem_wdata = 0.
- Data grant: mem_we = d_we, mem_sel = d_sel, mem_wdata = d_wdata.
REQ-007 The mem_* outputs SHALL hold stable for the whole of IF_BUSY and D_BUSY.
REQ-008 In a BUSY state, on the edge where mem_ready = 1, the block SHALL:
- latch mem_rdata into if_rdata or d_rdata (data writes latch too, and the value is don't-care);
- set the matching ack = 1 and bus_err = 0;
- set mem_ce = 0 and mem_we = 0;
- go to RESP.
REQ-009 A timeout counter (8 bits) SHALL clear on every grant edge and increment on each BUSY cycle with mem_ready = 0.
REQ-010 If the timeout counter reaches TIMEOUT-1 while mem_ready = 0, the next edge SHALL:
- set the matching ack = 1 and bus_err = 1;
- write 32'h0 to the matching rdata;
- drop mem_ce;
- go to RESP.
REQ-011 A mem_ready that arrives on the same edge as the timeout condition SHALL take precedence (normal completion, bus_err = 0).
REQ-012 RESP SHALL last exactly one cycle, with the ack high; the FSM SHALL then go to IDLE unconditionally, with no grant made from RESP.
REQ-013 Acks and bus_err SHALL be zero in every state except RESP.
REQ-014 Latency with memory ready at the Nth busy cycle (N >= 1):
- req first seen high at edge 0;
- mem_ce high from edge 0 to edge N;
- ack high for the cycle after edge N;
- a new grant at edge N+2 at the earliest.
REQ-015 A requester SHALL drop its req during its ack cycle; a req still high after RESP is a new request.
REQ-016 stallreq SHALL be combinational: (if_req & ~if_ack) | (d_req & ~d_ack).
REQ-017 mem_ready while the FSM is in IDLE or RESP SHALL be ignored.
REQ-018 if_rdata and d_rdata SHALL hold their last value until the next completion for that port.

Reset
REQ-019 While rst = 1, the block SHALL immediately (asynchronously) force:
- state IDLE and timeout counter 0;
- mem_ce, mem_we, if_ack, d_ack and bus_err to 0;
- mem_addr, mem_sel, mem_wdata, if_rdata and d_rdata to 0.
REQ-020 A reset asserted mid-transfer SHALL abandon that transfer with no ack; after reset release, pending requests SHALL be arbitrated afresh from IDLE.

Verification
REQ-021 Fetch read: if_req = 1, if_addr = 32'h0000_0010, mem_ready on the 2nd busy cycle with mem_rdata = 32'h3401_1100 -> mem_ce high 2 cycles, then if_ack 1 cycle with if_rdata = 32'h3401_1100.
REQ-022 Contention: if_req and d_req both rise at the same edge; d_we = 1, d_addr = 32'h80, d_sel = 4'b0011, d_wdata = 32'hDEAD_BEEF -> the data write is served first with those mem_* values; the fetch is granted 2 edges after d_ack.
REQ-023 Timeout: TIMEOUT = 4, mem_ready held 0 -> after 4 busy cycles, d_ack = 1, bus_err = 1 and d_rdata = 0, with mem_ce low in the same cycle.
REQ-024 Ready on the timeout edge: mem_ready = 1 at busy cycle TIMEOUT -> normal ack with bus_err = 0.
REQ-025 Stall: with if_req high -> stallreq stays 1 through the busy cycles and drops to 0 in the if_ack cycle.
REQ-026 Reset mid-transfer: rst pulse during D_BUSY -> mem_ce drops within the same cycle (asynchronously), no d_ack is ever issued, and a held d_req is re-granted on the first edge after release.
